vga_pattern_gen: RTL and testbench
==================================

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, iCLK cycles per pixel (even, >=2).
REQ-002 SHALL have parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, horizontal timing in pixels.
REQ-003 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical timing in lines.
REQ-004 SHALL have parameter COLOR_W, default 8, bits per colour channel.
REQ-005 SHALL have parameter SYNC_POL, default 0, asserted level of oVGA_HS/oVGA_VS.
REQ-006 SHALL have parameter CHECK_LOG2, default 5, checkerboard square size as log2 pixels.
REQ-007 SHALL have ports: iCLK in 1 system clock; iRST_N in 1 asynchronous active-low reset.
REQ-008 SHALL have ports: iRed/iGreen/iBlue in COLOR_W each, solid-mode colour; iMODE in 2, pattern select.
REQ-009 SHALL have ports: oVGA_R/oVGA_G/oVGA_B out COLOR_W each, pixel colour.
REQ-010 SHALL have ports: oVGA_HS, oVGA_VS, oVGA_BLANK (high = active video), oVGA_SYNC (constant 0), oVGA_CLOCK out 1 each.
REQ-011 SHALL have ports: oX out 11, oY out 10, active-area coordinates; oFrame_Start out 1, one-iCLK pulse.

Function
REQ-012 SHALL generate a pixel enable pix_en high for one iCLK every CLK_DIV iCLK cycles; oVGA_CLOCK high for the first CLK_DIV/2 cycles of each period.
REQ-013 SHALL advance h_cnt on pix_en, wrapping at H_ACTIVE+H_FP+H_SYNC+H_BP-1 to 0, and advance v_cnt on that wrap, wrapping at V total-1 to 0.
REQ-014 SHALL assert HS for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; VS likewise on v_cnt.
REQ-015 SHALL register colour, HS, VS, BLANK, oX, oY in one stage, updated on pix_en, all mutually aligned (latency one pixel after counter).
REQ-016 SHALL drive colour 0 whenever outside the active area.
REQ-017 SHALL latch iMODE only when h_cnt=0 and v_cnt=0 on pix_en; mode changes mid-frame take effect next frame.
REQ-018 Mode 0 SHALL output iRed/iGreen/iBlue sampled each active pixel.
REQ-019 Mode 1 SHALL output 8 bars of width H_ACTIVE/8: white, yellow, cyan, green, magenta, red, blue, black (full-scale channels), tracked by a bar counter, no divider.
REQ-020 Mode 2 SHALL output white when x[CHECK_LOG2]^y[CHECK_LOG2]=1, else black.
REQ-021 Mode 3 SHALL output R = x[COLOR_W-1:0], G = y[COLOR_W-1:0], B = iBlue.
REQ-022 SHALL pulse oFrame_Start for the one iCLK on which the registered outputs show pixel (0,0).
REQ-023 SHALL require H_ACTIVE divisible by 8; otherwise behaviour is undefined.

Reset
REQ-024 SHALL, while iRST_N=0, clear divider, h_cnt, v_cnt, mode (to 0), colours, oX, oY, oFrame_Start, oVGA_CLOCK, oVGA_BLANK to 0, and hold HS/VS at ~SYNC_POL.
REQ-025 SHALL, on reset mid-frame, restart at pixel (0,0) with the first pix_en CLK_DIV cycles after release.

Configuration
REQ-026 With VGA_PATGEN_BORDER_EN defined SHALL override colour with full-scale white on x=0, x=H_ACTIVE-1, y=0, y=V_ACTIVE-1 in all modes.
REQ-027 Without VGA_PATGEN_BORDER_EN SHALL output the mode pattern unmodified at the edges, with no border logic synthesised.

Structure
REQ-028 SHALL place the mode encoding (SOLID, BARS, CHECK, GRAD) and bar colour table in shared package vga_pkg.
REQ-029 SHALL implement the h/v counters and sync/blank decode in sub-module vga_timing; colour generation stays in vga_pattern_gen.

Verification
REQ-030 Defaults, reset released: HS period 1600 iCLK, low for 192; VS period 840000 iCLK, low for 2 lines; BLANK high 640 pixels/line, 480 lines/frame.
REQ-031 Mode 0, iRed=8'hA5, iGreen=8'h3C, iBlue=8'hFF: every active pixel = A5/3C/FF, every blanked pixel = 0/0/0.
REQ-032 Mode 1: pixel x=0 white FF/FF/FF, x=80 yellow FF/FF/00, x=639 black; bar transitions exactly at multiples of 80.
REQ-033 iMODE changed 0->2 at line 100: frame stays solid, next frame checker with (32,0) white, (0,0) black; oFrame_Start aligned with (0,0).
REQ-034 iRST_N pulsed low at h_cnt=300, v_cnt=200: outputs go to reset values immediately; after release first active pixel is (0,0), oFrame_Start fires.
REQ-035 VGA_PATGEN_BORDER_EN defined, mode 3: (0,y) and (639,y) white; (1,1) = 01/01/iBlue.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared mode encoding and colour-bar table for the VGA pattern generator
package vga_pkg;
  typedef enum logic [1:0] {SOLID = 2'd0, BARS = 2'd1, CHECK = 2'd2, GRAD = 2'd3} mode_t;
  // {r,g,b} channel enables, index 0 is the leftmost bar
  localparam logic [7:0][2:0] BAR_RGB = {3'b000, 3'b001, 3'b100, 3'b101,
                                         3'b010, 3'b011, 3'b110, 3'b111};
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    return BAR_RGB[idx];
  endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: horizontal/vertical pixel counters with raw sync and active-area decode
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  output logic [10:0] h_cnt,
  output logic [9:0]  v_cnt,
  output logic        h_last,
  output logic        hs,
  output logic        vs,
  output logic        active
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic v_last;
  assign h_last = h_cnt == 11'(H_TOTAL - 1);
  assign v_last = v_cnt == 10'(V_TOTAL - 1);
  assign hs = h_cnt >= 11'(H_ACTIVE + H_FP) && h_cnt < 11'(H_ACTIVE + H_FP + H_SYNC);
  assign vs = v_cnt >= 10'(V_ACTIVE + V_FP) && v_cnt < 10'(V_ACTIVE + V_FP + V_SYNC);
  assign active = h_cnt < 11'(H_ACTIVE) && v_cnt < 10'(V_ACTIVE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      h_cnt <= h_last ? '0 : h_cnt + 11'd1;
      if (h_last) v_cnt <= v_last ? '0 : v_cnt + 10'd1;
    end
endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: VGA test-pattern source (solid, colour bars, checkerboard, gradient).
// Define VGA_PATGEN_BORDER_EN to paint a white one-pixel frame around the active area.
module vga_pattern_gen import vga_pkg::*; #(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int COLOR_W    = 8,
  parameter bit SYNC_POL   = 1'b0,
  parameter int CHECK_LOG2 = 5
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  input  logic [1:0]         iMODE,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_HS,
  output logic               oVGA_VS,
  output logic               oVGA_BLANK,
  output logic               oVGA_SYNC,
  output logic               oVGA_CLOCK,
  output logic [10:0]        oX,
  output logic [9:0]         oY,
  output logic               oFrame_Start
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [10:0] BAR_LAST = 11'(H_ACTIVE / 8 - 1);
  logic [DIV_W-1:0] div, div_nxt;
  logic pix_en, h_last, hs, vs, active, frame_first, chk;
  logic [10:0] h_cnt, bar_cnt;
  logic [9:0] v_cnt;
  logic [2:0] bar_idx, bar;
  mode_t mode, cur_mode;
  logic [COLOR_W-1:0] r_pat, g_pat, b_pat, r_px, g_px, b_px;
  assign pix_en = div == DIV_W'(CLK_DIV - 1);
  assign div_nxt = pix_en ? '0 : div + 1'b1;
  assign oVGA_SYNC = 1'b0;
  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(iCLK), .rst_n(iRST_N), .pix_en(pix_en), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .h_last(h_last), .hs(hs), .vs(vs), .active(active)
  );
  // pixel (0,0) already uses the newly latched mode
  assign frame_first = h_cnt == '0 && v_cnt == '0;
  assign cur_mode = frame_first ? mode_t'(iMODE) : mode;
  assign bar = bar_rgb(bar_idx);
  assign chk = h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2];
  assign r_pat = cur_mode == SOLID ? iRed : cur_mode == BARS ? {COLOR_W{bar[2]}} :
                 cur_mode == CHECK ? {COLOR_W{chk}} : COLOR_W'(h_cnt);
  assign g_pat = cur_mode == SOLID ? iGreen : cur_mode == BARS ? {COLOR_W{bar[1]}} :
                 cur_mode == CHECK ? {COLOR_W{chk}} : COLOR_W'(v_cnt);
  assign b_pat = cur_mode == SOLID ? iBlue : cur_mode == BARS ? {COLOR_W{bar[0]}} :
                 cur_mode == CHECK ? {COLOR_W{chk}} : iBlue;
`ifdef VGA_PATGEN_BORDER_EN
  logic on_border;
  assign on_border = h_cnt == '0 || h_cnt == 11'(H_ACTIVE - 1) ||
                     v_cnt == '0 || v_cnt == 10'(V_ACTIVE - 1);
`endif
  always_comb begin
    {r_px, g_px, b_px} = {r_pat, g_pat, b_pat};
`ifdef VGA_PATGEN_BORDER_EN
    if (on_border) {r_px, g_px, b_px} = '1;
`endif
    if (!active) {r_px, g_px, b_px} = '0;
  end
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      div          <= '0;
      oVGA_CLOCK   <= 1'b0;
      oFrame_Start <= 1'b0;
      mode         <= SOLID;
      bar_cnt      <= '0;
      bar_idx      <= '0;
      oVGA_R       <= '0;
      oVGA_G       <= '0;
      oVGA_B       <= '0;
      oVGA_HS      <= ~SYNC_POL;
      oVGA_VS      <= ~SYNC_POL;
      oVGA_BLANK   <= 1'b0;
      oX           <= '0;
      oY           <= '0;
    end else begin
      div          <= div_nxt;
      oVGA_CLOCK   <= div_nxt < DIV_W'(CLK_DIV / 2);
      oFrame_Start <= pix_en && frame_first;
      if (pix_en) begin
        mode       <= cur_mode;
        bar_cnt    <= h_last || bar_cnt == BAR_LAST ? '0 : bar_cnt + 11'd1;
        bar_idx    <= h_last ? '0 : bar_cnt == BAR_LAST ? bar_idx + 3'd1 : bar_idx;
        oVGA_R     <= r_px;
        oVGA_G     <= g_px;
        oVGA_B     <= b_px;
        oVGA_HS    <= hs ? SYNC_POL : ~SYNC_POL;
        oVGA_VS    <= vs ? SYNC_POL : ~SYNC_POL;
        oVGA_BLANK <= active;
        oX         <= h_cnt;
        oY         <= v_cnt;
      end
    end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: scoreboard bench on a reduced 64x16 timing covering all modes,
// frame-boundary mode latching and a mid-frame asynchronous reset.
module tb_vga_pattern_gen;
  localparam int CD = 2, CL = 3;
  localparam int HA = 64, HF = 4, HSY = 8, HB = 4, HT = HA + HF + HSY + HB;
  localparam int VA = 16, VF = 2, VSY = 2, VB = 2, VT = VA + VF + VSY + VB;
  localparam bit SP = 1'b0;
  localparam logic [23:0] BAR_TB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  typedef struct packed {
    logic [7:0] r, g, b;
    logic hs, vs, blank, sync, clk;
    logic [10:0] x;
    logic [9:0] y;
    logic fs;
  } px_t;
  logic iCLK = 1'b0, iRST_N;
  logic [7:0] iRed, iGreen, iBlue;
  logic [1:0] iMODE;
  logic [7:0] oVGA_R, oVGA_G, oVGA_B;
  logic oVGA_HS, oVGA_VS, oVGA_BLANK, oVGA_SYNC, oVGA_CLOCK, oFrame_Start;
  logic [10:0] oX;
  logic [9:0] oY;
  int checks = 0, errors = 0;
  int mh = 0, mv = 0;
  logic [1:0] m_mode = 2'd0;
  px_t sb[$];
  always #5 iCLK = ~iCLK;
  vga_pattern_gen #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .COLOR_W(8), .SYNC_POL(SP), .CHECK_LOG2(CL)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .iMODE(iMODE),
    .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B), .oVGA_HS(oVGA_HS), .oVGA_VS(oVGA_VS),
    .oVGA_BLANK(oVGA_BLANK), .oVGA_SYNC(oVGA_SYNC), .oVGA_CLOCK(oVGA_CLOCK),
    .oX(oX), .oY(oY), .oFrame_Start(oFrame_Start)
  );
  function automatic px_t observed();
    return '{r: oVGA_R, g: oVGA_G, b: oVGA_B, hs: oVGA_HS, vs: oVGA_VS, blank: oVGA_BLANK,
             sync: oVGA_SYNC, clk: oVGA_CLOCK, x: oX, y: oY, fs: oFrame_Start};
  endfunction
  function automatic px_t exp_px(input int h, input int v, input logic [1:0] m);
    px_t e;
    logic [23:0] c;
    logic act;
    act = h < HA && v < VA;
    case (m)
      2'd0: c = {iRed, iGreen, iBlue};
      2'd1: c = BAR_TB[act ? h / (HA / 8) : 7];
      2'd2: c = (((h >> CL) ^ (v >> CL)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
      default: c = {8'(h), 8'(v), iBlue};
    endcase
`ifdef VGA_PATGEN_BORDER_EN
    if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) c = 24'hFFFFFF;
`endif
    if (!act) c = 24'h0;
    e.r = c[23:16];
    e.g = c[15:8];
    e.b = c[7:0];
    e.hs = (h >= HA + HF && h < HA + HF + HSY) ? SP : ~SP;
    e.vs = (v >= VA + VF && v < VA + VF + VSY) ? SP : ~SP;
    e.blank = act;
    e.sync = 1'b0;
    e.clk = 1'b1;
    e.x = 11'(h);
    e.y = 10'(v);
    e.fs = h == 0 && v == 0;
    return e;
  endfunction
  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] x);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, x);
    end
  endtask
  task automatic check_reset(input string tag);
    px_t r;
    r = '{r: 8'h0, g: 8'h0, b: 8'h0, hs: ~SP, vs: ~SP, blank: 1'b0, sync: 1'b0, clk: 1'b0,
          x: 11'h0, y: 10'h0, fs: 1'b0};
    check(tag, 64'(observed()), 64'(r));
  endtask
  // push the expectation for the pixel the counters are on, then pop it once it is registered
  task automatic pix_step();
    px_t e;
    string tag;
    if (mh == 0 && mv == 0) m_mode = iMODE;
    sb.push_back(exp_px(mh, mv, m_mode));
    tag = $sformatf("pix(%0d,%0d)m%0d", mh, mv, m_mode);
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv = (mv + 1) % VT;
    end
    for (int i = 0; i < CD; i++) begin
      @(posedge iCLK);
      #1;
      if (i == 0) check({tag, "_mid"}, 64'({oVGA_CLOCK, oFrame_Start}), 64'({1 < CD / 2, 1'b0}));
    end
    e = sb.pop_front();
    check(tag, 64'(observed()), 64'(e));
  endtask
  task automatic run_to(input int h, input int v, input int rnd);
    int n;
    n = 0;
    while (!(mh == h && mv == v) && n <= HT * VT) begin
      if (rnd == 1) {iRed, iGreen} = 16'($urandom);
      if (rnd == 2) iBlue = 8'($urandom);
      pix_step();
      n++;
    end
    check($sformatf("run_to(%0d,%0d)", h, v), 64'({mh, mv}), 64'({h, v}));
  endtask
  task automatic release_reset();
    @(negedge iCLK);
    iRST_N = 1'b1;
    mh = 0;
    mv = 0;
    m_mode = 2'd0;
    sb.delete();
  endtask
  initial begin
    iRST_N = 1'b0;
    iMODE = 2'd0;
    iRed = 8'hA5;
    iGreen = 8'h3C;
    iBlue = 8'hFF;
    repeat (3) @(posedge iCLK);
    #1;
    check_reset("reset_hold");
    release_reset();
    repeat (HT * VT) pix_step();
    iMODE = 2'd1;
    repeat (HT * VT) pix_step();
    iMODE = 2'd0;
    run_to(0, 8, 1);
    iMODE = 2'd2;
    {iRed, iGreen, iBlue} = 24'hA53CFF;
    run_to(0, 0, 0);
    repeat (HT * VT) pix_step();
    iMODE = 2'd3;
    run_to(30, 10, 2);
    iRST_N = 1'b0;
    #1;
    check_reset("reset_async");
    repeat (2) @(posedge iCLK);
    #1;
    check_reset("reset_mid_hold");
    release_reset();
    repeat (HT * VT + 5) pix_step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
